// File: rtl/bram64_symbol_ctrl.sv
// Symbol buffer controller: fills a 2^AW-word buffer from a valid/ready stream, then
// drains it in natural or FFT-shifted order with a one-cycle registered-read latency.
module bram64_symbol_ctrl #(
  parameter int DW = 13,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          shift_mode,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [7:0]    sym_count,
  output logic          drop_err,
  output logic          dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_valid while in_ready is low is a drop. The readout side has no backpressure.

  typedef enum logic {S_FILL = 1'b0, S_DRAIN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = '1;
  localparam logic [AW-1:0] HALF = {1'b1, {(AW-1){1'b0}}};

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic          r_mode;
  logic          r_out_valid;
  logic          r_out_last;
  logic [7:0]    r_sym_count;
  logic          r_drop_err;
  logic          w_rd_last;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    if (!rst) begin
      case (r_state)
        S_FILL: begin
          in_ready  = 1'b1;
          ram_we    = in_valid;
          ram_waddr = r_wr_cnt;
          if (in_valid && r_wr_cnt == LAST) w_next = S_DRAIN;
        end
        S_DRAIN: begin
          ram_re    = 1'b1;
          ram_raddr = r_rd_cnt ^ (r_mode ? HALF : '0);
          if (r_rd_cnt == LAST) w_next = S_FILL;
        end
        default: w_next = S_FILL;
      endcase
    end
  end

  assign w_rd_last = ram_re && (r_rd_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sym_count <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= ram_re;
      r_out_last  <= w_rd_last;
      if (ram_we) r_wr_cnt <= r_wr_cnt + 1'b1;
      // Readout mode is captured only on the symbol-completing write.
      if (ram_we && r_wr_cnt == LAST) begin
        r_mode   <= shift_mode;
        r_rd_cnt <= '0;
      end
      if (ram_re) r_rd_cnt <= r_rd_cnt + 1'b1;
      // Counted on the same edge that raises out_last, so the new count shows with it.
      if (w_rd_last) r_sym_count <= r_sym_count + 1'b1;
      if (in_valid && !in_ready) r_drop_err <= 1'b1;
    end
  end

  assign ram_wdata = in_data;
  assign out_data  = ram_rdata;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign sym_count = r_sym_count;
  assign drop_err  = r_drop_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bram64_symbol_ctrl.sv
// Randomized bench for bram64_symbol_ctrl: a RAM model, a stream driver with a symbol-level
// reference model feeding an expected queue, and a monitor that pops and compares readouts.
module tb_bram64_symbol_ctrl;
  localparam int DW = 13;
  localparam int AW = 6;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          shift_mode = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata = '0;
  logic [7:0]    sym_count;
  logic          drop_err;
  logic          dbg_state;

  bram64_symbol_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .shift_mode(shift_mode), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_re(ram_re),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .sym_count(sym_count),
    .drop_err(drop_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // registered-read buffer: data one cycle after ram_re, zero otherwise
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= ram_re ? mem[ram_raddr] : '0;
  end

  // scoreboard state
  logic [DW:0]   exp_q[$];
  int            last_q[$];
  int            wr0_q[$];
  logic [DW-1:0] sym_buf [N];
  int            acc_idx = 0;
  int            exp_sym = 0;
  logic          exp_drop = 1'b0;
  int            mon_cnt = 0;
  int            ready_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst) begin
      ready_low = 0;
    end else begin
      if (out_valid) begin
        mon_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
          chk("out_last", 32'(out_last), 32'(e[DW]));
          if (e[DW]) begin
            exp_sym = (exp_sym + 1) % 256;
            chk("sym_count_at_last", 32'(sym_count), 32'(exp_sym));
            last_q.push_back(cyc);
          end
        end
      end else if (out_last) begin
        chk("last_without_valid", 32'(out_last), 32'd0);
      end
      if (ram_we && ram_re) chk("we_re_same_cycle", 32'd1, 32'd0);
      if (in_ready) begin
        if (ready_low != 0) chk("ready_low_run", 32'(ready_low), 32'(N));
        ready_low = 0;
      end else begin
        ready_low++;
      end
    end
  end

  // driver: delivers n accepted samples; the symbol model builds the readout order
  task automatic run_samples(input int n, input logic mode, input int gap_pct,
                             input bit hold, input bit seq);
    int got = 0;
    int budget = 0;
    int idx;
    while (got < n && budget < n * 4 + 400) begin
      @(posedge clk); #1;
      budget++;
      if (($urandom_range(0, 99) < gap_pct) || (!in_ready && !hold)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = seq ? DW'(acc_idx) : DW'($urandom);
      end
      shift_mode = (acc_idx == N - 1) ? mode : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        chk("write_port", {16'(ram_waddr), 15'(ram_wdata), ram_we},
            {16'(acc_idx), 15'(in_data), 1'b1});
        if (acc_idx == 0) wr0_q.push_back(cyc);
        sym_buf[acc_idx] = in_data;
        if (acc_idx == N - 1) begin
          for (int k = 0; k < N; k++) begin
            idx = k ^ (mode ? N / 2 : 0);
            exp_q.push_back({1'(k == N - 1), sym_buf[idx]});
          end
        end
        acc_idx = (acc_idx + 1) % N;
        got++;
      end else if (in_valid) begin
        exp_drop = 1'b1;
        chk("drop_no_write", 32'(ram_we), 32'd0);
      end
    end
    if (got < n) chk("driver_timeout", 32'(got), 32'(n));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    exp_q.delete();
    acc_idx = 0;
    exp_sym = 0;
    exp_drop = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("reset_ports", {16'(ram_waddr), 8'(ram_raddr), in_ready, ram_we, ram_re}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_out", {out_valid, out_last, drop_err, in_ready}, 4'b0001);
    chk("post_reset_sym", 32'(sym_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    run_samples(N, 1'b0, 0, 1'b0, 1'b1);
    wait_drain();
    chk("natural_sym_count", 32'(sym_count), 32'd1);
    chk("natural_drop_err", 32'(drop_err), 32'd0);

    run_samples(N, 1'b1, 0, 1'b0, 1'b1);
    wait_drain();
    chk("fft_sym_count", 32'(sym_count), 32'd2);

    for (int s = 0; s < 4; s++) run_samples(N, 1'($urandom_range(0, 1)), 30, 1'b0, 1'b0);
    wait_drain();
    chk("random_sym_count", 32'(sym_count), 32'd6);
    chk("random_drop_err", 32'(drop_err), 32'(exp_drop));

    wr0_q.delete();
    last_q.delete();
    run_samples(N, 1'b1, 0, 1'b1, 1'b0);
    run_samples(N, 1'b0, 0, 1'b1, 1'b0);
    wait_drain();
    chk("b2b_sym_count", 32'(sym_count), 32'd8);
    chk("b2b_drop_err", 32'(drop_err), 32'd1);
    if (wr0_q.size() >= 2 && last_q.size() >= 1) chk("b2b_overlap_cycle", 32'(wr0_q[1]), 32'(last_q[0]));
    else chk("b2b_overlap_events", 32'(wr0_q.size() + last_q.size()), 32'd3);

    run_samples(N, 1'b0, 20, 1'b0, 1'b0);
    mon_cnt = 0;
    for (int b = 0; b < 100 && mon_cnt < 10; b++) @(negedge clk);
    chk("mid_drain_outputs", 32'(mon_cnt), 32'd10);
    do_reset(1);
    run_samples(N, 1'b1, 10, 1'b0, 1'b0);
    wait_drain();
    chk("after_reset_sym_count", 32'(sym_count), 32'd1);

    do_reset(1);
    for (int s = 0; s < 256; s++) run_samples(N, 1'($urandom_range(0, 1)), 0, 1'b1, 1'b0);
    wait_drain();
    chk("wrap_sym_count", 32'(sym_count), 32'd0);
    chk("wrap_drop_err", 32'(drop_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram64_symbol_ctrl.md
BRAM64_SYMBOL_CTRL -- requirements
Module: bram64_symbol_ctrl

Interface
REQ-001 SHALL have parameter DW, default 13: sample width, equal to the buffer word width.
REQ-002 SHALL have parameter AW, default 6: buffer address width; depth is 2^AW (64).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream sample valid.
REQ-006 SHALL have port in_data, input, DW: upstream sample.
REQ-007 SHALL have port in_ready, output, 1: sample accepted when in_valid && in_ready.
REQ-008 SHALL have port shift_mode, input, 1: 0 selects natural readout; 1 selects FFT-shift readout (address XOR 2^(AW-1)).
REQ-009 SHALL have port out_valid, output, 1: readout sample valid; no backpressure.
REQ-010 SHALL have port out_data, output, DW: readout sample.
REQ-011 SHALL have port out_last, output, 1: marks the 64th readout sample of a symbol.
REQ-012 SHALL have port ram_we, output, 1: buffer write enable.
REQ-013 SHALL have port ram_waddr, output, AW: buffer write address.
REQ-014 SHALL have port ram_wdata, output, DW: buffer write data.
REQ-015 SHALL have port ram_re, output, 1: buffer read enable.
REQ-016 SHALL have port ram_raddr, output, AW: buffer read address.
REQ-017 SHALL have port ram_rdata, input, DW: buffer read data; registered, valid 1 cycle after ram_re, zero otherwise.
REQ-018 SHALL have port sym_count, output, 8: count of completed symbols, wrapping 255->0.
REQ-019 SHALL have port drop_err, output, 1: sticky; set when in_valid is high while in_ready is low.

Function
REQ-020 SHALL implement a two-state FSM, FILL and DRAIN.
REQ-021 SHALL, in FILL, drive in_ready=1 and ram_re=0.
REQ-022 SHALL, in DRAIN, drive in_ready=0.
REQ-023 SHALL, in FILL, combinationally drive ram_we=in_valid, ram_waddr=wr_cnt and ram_wdata=in_data on every accepted sample, then increment wr_cnt.
REQ-024 SHALL, on the accept with wr_cnt=63, wrap wr_cnt to 0, latch shift_mode into mode_q, clear rd_cnt, and enter DRAIN next cycle.
REQ-025 SHALL ignore shift_mode at all other times.
REQ-026 SHALL, in DRAIN, assert ram_re=1 every cycle with ram_raddr = rd_cnt XOR (mode_q ? 2^(AW-1) : 0), incrementing rd_cnt each cycle.
REQ-027 SHALL, on the cycle rd_cnt=63 is issued, return to FILL next cycle with in_ready=1 in that cycle.
REQ-028 SHALL make out_valid a 1-cycle-delayed copy of ram_re and out_last a 1-cycle-delayed copy of (ram_re && rd_cnt==63).
REQ-029 SHALL pass ram_rdata combinationally to out_data.
REQ-030 SHALL have a latency of 1 cycle from read issue to out_valid, and exactly 64 cycles of DRAIN per symbol.
REQ-031 SHALL allow the final out_valid/out_last of one symbol to coincide with the first write of the next symbol; this is legal, with no stall and no data corruption.
REQ-032 SHALL increment sym_count in the cycle out_last is asserted.
REQ-033 SHALL, for in_valid during DRAIN, drop the sample with no RAM write and set drop_err=1 until reset.
REQ-034 SHALL tolerate in_valid gaps in FILL: no write, wr_cnt holds, no timeout.
REQ-035 SHALL never assert ram_we and ram_re at the same address in the same cycle.

Reset
REQ-036 SHALL, on rst=1 at a rising edge, set state=FILL, wr_cnt=0, rd_cnt=0, mode_q=0, sym_count=0, drop_err=0, out_valid=0, out_last=0.
REQ-037 SHALL, during reset, drive ram_we=0, ram_re=0, ram_waddr=0, ram_raddr=0 and in_ready=0.
REQ-038 SHALL, on reset mid-FILL or mid-DRAIN, abort the partial symbol with no out_last and no sym_count change; the next symbol starts at address 0.

Verification
REQ-039 SHALL verify natural order: write 0..63 with shift_mode=0 -> 64 out_valid cycles, out_data 0..63, out_last on value 63, sym_count=1.
REQ-040 SHALL verify FFT-shift: write 0..63 with shift_mode=1 at the 64th accept -> out_data 32..63 then 0..31, out_last on 31.
REQ-041 SHALL verify back-to-back symbols: continuous in_valid -> in_ready low exactly 64 cycles per symbol; second symbol's first write coincides with first symbol's out_last; sym_count=2.
REQ-042 SHALL verify drops: in_valid held high through DRAIN -> no ram_we during DRAIN, drop_err=1 sticky, output values unaffected.
REQ-043 SHALL verify mid-drain reset: rst pulsed after 10 readout samples -> out_valid=0 the following cycle, sym_count=0, the next 64 writes land at addresses 0..63.
REQ-044 SHALL verify sym_count wrap: 256 symbols -> sym_count returns to 0.
